uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with a small input FIFO, replacing the fixed 8N1 transmitter in the serial link datapath. It takes words from the host-side logic, buffers them, and serialises them LSB-first at an oversampled tick rate. Data width, oversampling ratio and FIFO depth are set by parameters. Parity and stop-bit length are selected at run time. It shares the existing baud-rate tick generator with the receiver.

## Interface
- `DBIT`, 8: data bits per frame, legal 5..9.
- `OS_TICK`, 16: `s_tick` pulses per bit period, even, legal 4..64.
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW entries.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `s_tick`  in  1  oversampling tick, one `clk` wide.
- `wr_en`  in  1  write strobe for `din`.
- `din`  in  DBIT  data word.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop_mode`  in  2  00 one, 01 one-and-a-half, 10 two, 11 two.
- `full`  out  1  FIFO holds 2^FIFO_AW words.
- `empty`  out  1  FIFO holds 0 words.
- `busy`  out  1  FSM not in IDLE.
- `overrun`  out  1  one-clk pulse when a write is dropped.
- `tx_done_tick`  out  1  one-clk pulse at the end of each frame.
- `tx`  out  1  serial line, registered output.

## Operation
- Reset values:
  - `tx`=1, `full`=0, `empty`=1, `busy`=0, `overrun`=0, `tx_done_tick`=0.
  - FSM in IDLE, FIFO pointers and count = 0.
- Reset mid-frame aborts the frame immediately and discards all FIFO contents.
- FIFO writes:
  - A write is accepted when `wr_en`=1 and `full`=0 in that cycle.
  - If `wr_en`=1 and `full`=1, the word is dropped and `overrun`=1 in that cycle, even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1.
  - If `empty`=0, pop the head word into the shift register.
  - In the same cycle, latch `parity_mode` and `stop_mode` into frame registers, clear the tick counter, and go to START.
  - Config is held constant for the whole frame. Changing the inputs mid-frame has no effect until the next frame.
- START: `tx`=0 for `OS_TICK` ticks, then go to DATA with the bit counter cleared.
- DATA:
  - `tx` = shift register bit 0.
  - Every `OS_TICK` ticks, shift right and increment the bit counter.
  - After bit `DBIT-1`: go to PARITY if the latched parity is even or odd, otherwise go to STOP.
- PARITY:
  - `tx` = XOR of the `DBIT` data bits, inverted for odd parity. This bit is accumulated during DATA.
  - Duration is `OS_TICK` ticks, then go to STOP.
- STOP:
  - `tx`=1.
  - Duration: `OS_TICK`, `OS_TICK*3/2` or `2*OS_TICK` ticks for stop_mode 00, 01, or 10/11 respectively.
  - On the last tick, `tx_done_tick`=1 (combinational, same cycle as that `s_tick`).
  - Then, if the FIFO is non-empty, pop and go directly to START, so frames have no gap. Otherwise go to IDLE.
- Width rules:
  - Tick counter width is $clog2(2*OS_TICK).
  - Bit counter width is $clog2(DBIT).
  - Count register width is FIFO_AW+1.
  - Pointers wrap modulo 2^FIFO_AW.

## Timing
- Write-to-line latency when idle:
  - Write in cycle N makes `empty`=0 in cycle N+1.
  - The pop and move to START happen in N+1.
  - `tx` falls in cycle N+2.
- Bit boundaries are counted in `s_tick` pulses, not clocks.
- `tx` changes one clk after the state or shift-register change that causes it.
- `full`, `empty` and `busy` are registered. They update the cycle after a push or pop.
- A simultaneous push and pop leaves the count unchanged. This is legal whenever `full`=0.
- Frame length in ticks = `OS_TICK*(1+DBIT+P)` + stop ticks, where P is 1 with parity and 0 without.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state and parity accumulator are built, and `parity_mode` behaves as above.
  - Undefined: the port remains but is ignored. DATA always goes to STOP, and no parity logic is synthesised.

## Test plan
- Write 0x55, none/one stop, DBIT=8, OS_TICK=16:
  - `tx` low for ticks 0–15, then data bits 1,0,1,0,1,0,1,0 at 16 ticks each, then high for 16 ticks.
  - `tx_done_tick` on tick 160.
  - `busy` falls next clk.
- Write 0x07 with even parity: parity bit=1, frame is 176 ticks. Repeat with odd parity: parity bit=0.
- Write 0xA3 with stop_mode 01 and then 10: stop lasts 24 and 32 ticks respectively, and `tx_done_tick` falls at 184 and 192 ticks.
- Six consecutive writes 0x01..0x06 with FIFO_AW=2:
  - The first word is popped after one cycle, so writes 2–5 fill the FIFO.
  - The sixth write gets `overrun`=1 and is dropped.
  - Five frames 0x01..0x05 go out back-to-back with no extra high period between stop and start.
  - `empty`=1 after the fifth pop.
- Assert `reset` during DATA bit 3: `tx`=1 immediately, `empty`=1, `busy`=0, no `tx_done_tick`. A later write of 0x3C transmits a correct full frame.
- Build without `UART_TX_PARITY_EN`, parity_mode=01, write 0x07: no parity bit is sent, `tx_done_tick` on tick 160.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small input FIFO.
// Each frame is: start bit, DBIT data bits sent LSB first, an optional parity
// bit, then 1, 1.5 or 2 stop bits. Every bit lasts OS_TICK pulses of s_tick.
// Parity and stop length are sampled from parity_mode/stop_mode when a word is
// popped, so each frame keeps one fixed configuration.
// Build option: define UART_TX_PARITY_EN to include the PARITY state and the
// parity accumulator. Without it, parity_mode is accepted but has no effect.

module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int OS_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      parity_mode,
  input  logic [1:0]      stop_mode,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic            overrun,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(2 * OS_TICK);
  localparam int BW    = $clog2(DBIT);

  localparam logic [TW-1:0]    TICK_ONE    = TW'(1);
  localparam logic [TW-1:0]    BIT_LAST_T  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0]    STOP15_LAST = TW'(OS_TICK * 3 / 2 - 1);
  localparam logic [TW-1:0]    STOP2_LAST  = TW'(2 * OS_TICK - 1);
  localparam logic [BW-1:0]    BIT_ONE     = BW'(1);
  localparam logic [BW-1:0]    DATA_LAST   = BW'(DBIT - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DBIT-1:0]    mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, empty_q;
  logic               push, pop;
  logic [DBIT-1:0]    head;

  // A write is taken only while not full; a full FIFO drops it and flags
  // overrun, even in a cycle where the FSM pops.
  assign push    = wr_en & ~full_q;
  assign overrun = wr_en & full_q;
  assign head    = mem_q[rptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Storage array write port.
  // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= din;
    end
  end

  // Occupancy next value; a simultaneous push and pop leaves it unchanged.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and the registered full/empty flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM and frame datapath
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [1:0]      stop_cfg_q, stop_cfg_d;
  logic [TW-1:0]   stop_last;
  logic            frame_end;
  logic            tx_q, tx_d;
  logic            busy_q;

`ifdef UART_TX_PARITY_EN
  logic [1:0] par_cfg_q, par_cfg_d;
  logic       par_acc_q, par_acc_d;
  logic       par_on;

  // Parity is sent only for even (01) and odd (10); 00 and 11 mean none.
  assign par_on = (par_cfg_q == 2'b01) | (par_cfg_q == 2'b10);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  // Last tick index of the stop period for the frame's latched stop length.
  always_comb begin
    stop_last = BIT_LAST_T;
    case (stop_cfg_q)
      2'b00:   stop_last = BIT_LAST_T;
      2'b01:   stop_last = STOP15_LAST;
      default: stop_last = STOP2_LAST;
    endcase
  end

  // State register and frame datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      stop_cfg_q <= 2'b00;
`ifdef UART_TX_PARITY_EN
      par_cfg_q  <= 2'b00;
      par_acc_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      stop_cfg_q <= stop_cfg_d;
`ifdef UART_TX_PARITY_EN
      par_cfg_q  <= par_cfg_d;
      par_acc_q  <= par_acc_d;
`endif
    end
  end

  // Next-state logic: bit periods are counted in s_tick pulses; a pop loads
  // the next word and the frame configuration and restarts the tick counter.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    stop_cfg_d = stop_cfg_q;
    frame_end  = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_cfg_d  = par_cfg_q;
    par_acc_d  = par_acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST_T) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      S_DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST_T) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
`ifdef UART_TX_PARITY_EN
            par_acc_d = par_acc_q ^ shreg_q[0];
`endif
            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = par_on ? S_PARITY : S_STOP;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST_T) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
`endif

      S_STOP: begin
        if (s_tick) begin
          if (tick_q == stop_last) begin
            frame_end = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (!empty_q) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shreg_d    = head;
      tick_d     = '0;
      stop_cfg_d = stop_mode;
`ifdef UART_TX_PARITY_EN
      par_cfg_d  = parity_mode;
      par_acc_d  = 1'b0;
`endif
    end
  end

  // Output logic: the line level is derived from the next state so the
  // registered tx lines up with the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_acc_d ^ (par_cfg_d == 2'b10);
`endif
      default: tx_d = 1'b1;
    endcase
    tx_done_tick = frame_end;
  end

  // Registered line and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= (state_d != S_IDLE);
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (DBIT=8, OS_TICK=16,
// FIFO_AW=2). A line monitor decodes every frame and compares it against a
// scoreboard queue filled when words are written.

module tb_uart_tx_fifo;

  localparam int DBIT     = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 3;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         has_par;
    logic       par_bit;
    int         len;
    bit         b2b;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic [1:0] par;
    logic [1:0] stp;
    int         exp_len;
    bit         exp_has_par;
    logic       exp_par_bit;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       wr_en;
  logic [7:0] din;
  logic [1:0] parity_mode;
  logic [1:0] stop_mode;
  logic       full, empty, busy, overrun, tx_done_tick, tx;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Monitor state
  bit         mon_active = 1'b0;
  int         mon_tick = 0;
  int         frames_started = 0;
  int         frames_done = 0;
  int         done_pulses = 0;
  longint     cyc = 0;
  longint     last_done_cyc = -100;
  logic [7:0] mon_data;
  logic       mon_par, mon_stop;
  exp_t       cur;
  bit         cur_valid;

  uart_tx_fifo #(.DBIT(DBIT), .OS_TICK(OS), .FIFO_AW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .wr_en        (wr_en),
    .din          (din),
    .parity_mode  (parity_mode),
    .stop_mode    (stop_mode),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
    .overrun      (overrun),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  // One-clk-wide oversampling tick every TICK_DIV clocks.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] d, input bit hp, input logic pb,
                                  input int len, input bit b2b);
    exp_t e;
    e.data = d; e.has_par = hp; e.par_bit = pb; e.len = len; e.b2b = b2b;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [7:0] d, input logic [1:0] p, input logic [1:0] s,
                                  input int len, input bit hp, input logic pb);
    vec_t v;
    v.din = d; v.par = p; v.stp = s; v.exp_len = len; v.exp_has_par = hp; v.exp_par_bit = pb;
    return v;
  endfunction

  // Line monitor: decodes frames mid-bit, measures frame length in ticks up to
  // and including the tx_done_tick pulse, and checks back-to-back spacing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mon_active = 1'b0;
      end else begin
        if (tx_done_tick) begin
          done_pulses++;
          check("done_inside_frame_tick", 32'(mon_active && s_tick), 32'd1);
        end
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          mon_tick   = 0;
          mon_data   = '0;
          mon_par    = 1'bx;
          mon_stop   = 1'bx;
          frames_started++;
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          cur_valid = (exp_q.size() > 0);
          if (cur_valid) begin
            cur = exp_q.pop_front();
            if (cur.b2b) check("b2b_gap_clks", 32'(cyc - last_done_cyc), 32'd1);
          end
        end
        if (mon_active && s_tick) begin
          if (mon_tick == OS / 2) check("start_bit", 32'(tx), 32'd0);
          if (mon_tick >= OS && mon_tick < (1 + DBIT) * OS && (mon_tick % OS) == OS / 2)
            mon_data = {tx, mon_data[7:1]};
          if (cur_valid) begin
            if (cur.has_par && mon_tick == (1 + DBIT) * OS + OS / 2) mon_par = tx;
            if (mon_tick == (1 + DBIT + (cur.has_par ? 1 : 0)) * OS + OS / 2) mon_stop = tx;
          end
          if (tx_done_tick) begin
            if (cur_valid) begin
              check("frame_len_ticks", 32'(mon_tick + 1), 32'(cur.len));
              check("frame_data", 32'(mon_data), 32'(cur.data));
              if (cur.has_par) check("parity_bit", 32'(mon_par), 32'(cur.par_bit));
              check("stop_bit", 32'(mon_stop), 32'd1);
            end
            mon_active    = 1'b0;
            last_done_cyc = cyc;
            frames_done++;
          end
          mon_tick++;
        end
      end
    end
  end

  task automatic wait_started(input int target, input string name);
    int budget = 3000;
    while (frames_started < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check(name, 32'(frames_started >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input string name);
    int budget = 3000;
    while (frames_done < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check(name, 32'(frames_done >= target), 32'd1);
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  vec_t vec[6];

  initial begin
    int fs, fd, dp;

    vec[0] = mk_vec(8'hC6, 2'b00, 2'b01, 168, 1'b0, 1'b0);
    vec[1] = mk_vec(8'h07, 2'b01, 2'b00, PAR_EN ? 176 : 160, PAR_EN, 1'b1);
    vec[2] = mk_vec(8'h07, 2'b10, 2'b00, PAR_EN ? 176 : 160, PAR_EN, 1'b0);
    vec[3] = mk_vec(8'hA3, 2'b01, 2'b01, PAR_EN ? 184 : 168, PAR_EN, 1'b0);
    vec[4] = mk_vec(8'hA3, 2'b10, 2'b10, PAR_EN ? 192 : 176, PAR_EN, 1'b1);
    vec[5] = mk_vec(8'h81, 2'b11, 2'b11, 176, 1'b0, 1'b0);

    reset = 1'b1; wr_en = 1'b0; din = '0; parity_mode = 2'b00; stop_mode = 2'b00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle write-to-line latency with 0x55, no parity, one stop bit
    fd = frames_done;
    din = 8'h55; wr_en = 1'b1; parity_mode = 2'b00; stop_mode = 2'b00;
    exp_q.push_back(mk_exp(8'h55, 1'b0, 1'b0, 160, 1'b0));
    @(negedge clk);
    check("lat_empty_cN", 32'(empty), 32'd1);
    check("lat_overrun_cN", 32'(overrun), 32'd0);
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    check("lat_empty_cN1", 32'(empty), 32'd0);
    check("lat_tx_cN1", 32'(tx), 32'd1);
    check("lat_busy_cN1", 32'(busy), 32'd0);
    @(negedge clk);
    check("lat_tx_cN2", 32'(tx), 32'd0);
    check("lat_busy_cN2", 32'(busy), 32'd1);
    check("lat_empty_cN2", 32'(empty), 32'd1);
    wait_done(fd + 1, "lat_frame_done");
    @(negedge clk);
    check("lat_busy_fall", 32'(busy), 32'd0);
    check("lat_tx_idle", 32'(tx), 32'd1);

    // Table-driven single frames; config inputs are flipped mid-frame and
    // must not affect the frame in flight.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      fs = frames_started;
      fd = frames_done;
      parity_mode = vec[i].par; stop_mode = vec[i].stp;
      din = vec[i].din; wr_en = 1'b1;
      exp_q.push_back(mk_exp(vec[i].din, vec[i].exp_has_par, vec[i].exp_par_bit,
                             vec[i].exp_len, 1'b0));
      @(posedge clk); #1 wr_en = 1'b0;
      wait_started(fs + 1, "vec_frame_start");
      #1;
      parity_mode = parity_mode ^ 2'b11;
      stop_mode   = stop_mode ^ 2'b11;
      wait_done(fd + 1, "vec_frame_done");
      @(negedge clk);
      check("vec_busy_fall", 32'(busy), 32'd0);
      check("vec_empty_after", 32'(empty), 32'd1);
    end

    // Six back-to-back writes: five accepted, sixth overruns
    @(posedge clk); #1;
    parity_mode = 2'b00; stop_mode = 2'b00;
    fs = frames_started;
    fd = frames_done;
    for (int k = 1; k <= 6; k++) begin
      din = 8'(k); wr_en = 1'b1;
      if (k <= 5) exp_q.push_back(mk_exp(8'(k), 1'b0, 1'b0, 160, k > 1));
      @(negedge clk);
      check("burst_overrun", 32'(overrun), 32'(k == 6));
      check("burst_full", 32'(full), 32'(k == 6));
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("burst_overrun_clear", 32'(overrun), 32'd0);
    check("burst_full_hold", 32'(full), 32'd1);
    wait_started(fs + 4, "burst_start4");
    @(negedge clk);
    check("burst_empty_at4", 32'(empty), 32'd0);
    wait_started(fs + 5, "burst_start5");
    @(negedge clk);
    check("burst_empty_at5", 32'(empty), 32'd1);
    wait_done(fd + 5, "burst_done");
    @(negedge clk);
    check("burst_busy_fall", 32'(busy), 32'd0);

    // Reset during DATA bit 3 with a second word waiting in the FIFO
    @(posedge clk); #1;
    din = 8'h00; wr_en = 1'b1;
    exp_q.push_back(mk_exp(8'h00, 1'b0, 1'b0, 160, 1'b0));
    @(posedge clk); #1;
    din = 8'hFF;
    exp_q.push_back(mk_exp(8'hFF, 1'b0, 1'b0, 160, 1'b1));
    @(posedge clk); #1 wr_en = 1'b0;
    begin
      int budget = 3000;
      while (!(mon_active && mon_tick >= OS + 3 * OS + OS / 2) && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      check("rst_reach_bit3", 32'(mon_active && mon_tick >= OS + 3 * OS + OS / 2), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_done", 32'(tx_done_tick), 32'd0);
    exp_q.delete();
    dp = done_pulses;
    fs = frames_started;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("postrst_no_done", 32'(done_pulses), 32'(dp));
    check("postrst_no_frame", 32'(frames_started), 32'(fs));
    check("postrst_tx", 32'(tx), 32'd1);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_empty", 32'(empty), 32'd1);

    // Full frame after the aborted one
    @(posedge clk); #1;
    fd = frames_done;
    parity_mode = 2'b00; stop_mode = 2'b00;
    din = 8'h3C; wr_en = 1'b1;
    exp_q.push_back(mk_exp(8'h3C, 1'b0, 1'b0, 160, 1'b0));
    @(posedge clk); #1 wr_en = 1'b0;
    wait_done(fd + 1, "final_frame_done");
    @(negedge clk);
    check("final_busy_fall", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
